// File: rtl/core_pkg.sv
// Shared types and constants for the instruction fetch front end.
package core_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that empties it in one cycle.
// Head entry is read straight from the storage registers.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           wdata,
    input  logic                   pop,
    output fetch_entry_t           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign do_pop_s  = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push_s = push && (!full_s || do_pop_s);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;

    // next-state for pointers, occupancy and storage
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage registers; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, response FIFO, redirects.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the decoder when the FIFO is empty.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    input  logic        insn_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [CNT_W:0]   credit_sum_s;
    logic             accept_s;
    logic             resp_s;
    logic             keep_s;
    logic             discard_s;
    logic             bypass_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    fetch_entry_t     fifo_wdata_s;
    fetch_entry_t     fifo_rdata_s;

    // in-flight requests plus buffered words never exceed the FIFO size
    assign credit_sum_s = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
    assign imem_req     = !reset && (credit_sum_s < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_addr    = fetch_pc_q;
    assign accept_s     = imem_req && imem_gnt;

    assign resp_s    = imem_rvalid && !reset && (outstanding_q != {CNT_W{1'b0}});
    assign discard_s = resp_s && (drop_q != {CNT_W{1'b0}});
    assign keep_s    = resp_s && (drop_q == {CNT_W{1'b0}}) && !redirect_en;

`ifdef FETCH_BYPASS_EN
    assign bypass_s = keep_s && fifo_empty_s && insn_ready;
`else
    assign bypass_s = 1'b0;
`endif

    assign fifo_push_s  = keep_s && !bypass_s;
    assign fifo_pop_s   = !fifo_empty_s && insn_ready && !redirect_en;
    assign fifo_wdata_s = '{pc: resp_pc_q, insn: imem_rdata};
    assign insn_valid   = !fifo_empty_s || bypass_s;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_en),
        .push  (fifo_push_s),
        .wdata (fifo_wdata_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // decoder-facing word and PC, NOP/0 when nothing is presented
    always_comb begin
        insn    = NOP_INSN;
        insn_pc = 32'h0000_0000;
        if (!fifo_empty_s) begin
            insn    = fifo_rdata_s.insn;
            insn_pc = fifo_rdata_s.pc;
        end else if (bypass_s) begin
            insn    = imem_rdata;
            insn_pc = resp_pc_q;
        end else begin
            insn    = NOP_INSN;
            insn_pc = 32'h0000_0000;
        end
    end

    // PC, outstanding and drop-count next state
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(accept_s) - CNT_W'(resp_s);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        if (redirect_en) begin
            // everything still in flight, including this cycle's accept, is stale
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            drop_d     = outstanding_d;
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (keep_s) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (discard_s) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // fetch state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= {CNT_W{1'b0}};
            drop_q        <= {CNT_W{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: owns the program counter and issues word reads to instruction memory. Buffers returned words with their PCs in a small FIFO and presents them to the instruction decoder over a valid/ready handshake. Branch, JAL and JALR resolution redirect it. It is the producer of the 32-bit instruction word the decoder consumes.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; low 2 bits must be 0.
- FIFO_DEPTH, 4: buffered instructions; power of two, 2..16; also caps outstanding requests.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  read request valid.
- imem_addr  out  32  word address, bits [1:0] always 0.
- imem_gnt  in  1  request accepted when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid; one per accepted request, in order, ≥1 cycle after acceptance.
- imem_rdata  in  32  response word.
- redirect_en  in  1  control-flow redirect, single-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- insn_valid  out  1  insn/insn_pc valid.
- insn  out  32  instruction word; NOP (32'h0000_0013) when !insn_valid.
- insn_pc  out  32  address of insn; 0 when !insn_valid.
- insn_ready  in  1  consumer accepts when insn_valid && insn_ready.

## Operation
- State: fetch_pc, outstanding count (0..FIFO_DEPTH), drop count, FIFO of {pc, insn}.
- imem_req = !reset && (outstanding + fifo_count < FIFO_DEPTH). This credit rule guarantees every response has a slot and the FIFO never overflows.
- imem_addr = fetch_pc. On accept, fetch_pc += 4, wrapping mod 2^32 (32'hFFFF_FFFC → 0).
- Response with drop count 0: pushed as {pc of matching request, imem_rdata}.
- Response with drop count > 0: discarded; drop count decrements.
- Per-request PC is tracked by a PC counter that follows accepted requests minus discards. Resp PC = redirect base + 4×(kept responses).
- Pop on insn_valid && insn_ready. Simultaneous push and pop on a full FIFO is legal.
- Redirect in cycle T:
  - Next cycle: fetch_pc = redirect_pc & ~3, FIFO empty, drop count = outstanding_next (outstanding + accept_T − rvalid_T).
  - The request accepted in T, if any, is stale and counted in drop count.
  - Response in T is discarded.
  - Pop in T is void: the instruction is killed, not consumed.
  - Redirect while drops are pending is legal; the same formula applies.
- imem_req/imem_addr may change while ungranted only on redirect or reset. Otherwise they hold stable until grant.
- Reset mid-operation: all counters and the FIFO clear. Responses arriving after reset for pre-reset requests are a memory-side error. Memory must be reset together with the fetch unit.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, insn_valid 0, insn 32'h0000_0013, insn_pc 0. fetch_pc = RESET_PC, counters 0.
- First cycle after reset deassertion: imem_req=1, imem_addr=RESET_PC.
- Gnt always 1 and rvalid 1 cycle after accept: one accept per cycle sustained at full throughput with insn_ready=1.
- Latency, rvalid cycle R to insn_valid: R+1 (registered FIFO path).
- Redirect at T: imem_addr = new target at T+1. The earliest new instruction is valid at T+3 with 1-cycle memory.

## Configuration
- FETCH_BYPASS_EN: when defined, a kept response arriving while the FIFO is empty and insn_ready=1 drives insn/insn_pc/insn_valid combinationally in cycle R and is not written.
  - Latency becomes 0 cycles; insn_valid depends combinationally on imem_rvalid.
- Not defined: all outputs come from FIFO registers; latency is 1 cycle.
- Credit rule and redirect behaviour are identical in both builds.

## Structure
- core_pkg holds:
  - NOP_INSN = 32'h0000_0013
  - default RESET_PC
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] insn;}
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t with depth FIFO_DEPTH and a flush input.
- Counters and PC logic stay in fetch_unit.

## Test plan
- Reset release, gnt=1, 1-cycle memory returning addr^32'hA5A5_0000, insn_ready=1.
  - Requests at 0,4,8,…
  - insn_pc 0,4,8 on consecutive cycles with the matching data.
- insn_ready=0 held:
  - Exactly FIFO_DEPTH accepts, then imem_req=0.
  - Raising ready drains the FIFO in order and restarts requests.
- Memory latency 3 with 3 outstanding, redirect to 32'h100 (low bits 2'b11):
  - Next imem_addr=32'h100.
  - The 3 stale responses are dropped.
  - First insn_pc=32'h100.
- Redirect in the same cycle as an accept and a pop:
  - The accepted request is dropped.
  - The popped word never counts as consumed.
  - The FIFO is empty next cycle.
- fetch_pc=32'hFFFF_FFF8: the two requests after it go to 32'hFFFF_FFFC and then 0; the PCs are tagged correctly.
- Reset asserted mid-stream with a full FIFO: next cycle shows the full reset values. The first request after reset deassertion goes to RESET_PC.
